multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Sequential successor to the single-cycle opcode decoder for the MIPS datapath.
- Moore FSM that sequences each instruction over 3–5 cycles through a shared ALU and a unified instruction/data memory.
- Memory accesses use a ready handshake, guarded by a timeout.
- Flags illegal opcodes and memory timeouts, and pulses a retire strobe for each completed instruction.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for mem_ready in a memory state before trapping (1..2^TO_W-1)
TO_W, 5, width of the wait counter
TRAP_ILLEGAL, 1, 1: illegal opcode enters TRAP; 0: illegal opcode retires as NOP

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
op  input  6  opcode from instruction register; valid from DECODE onward
mem_ready  input  1  memory completed the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  conditional PC load; taken when (zero ^ branch_ne)
branch_ne  output  1  selects bne sense for pc_write_cond
pc_src  output  2  00 ALU result, 01 ALUOut register, 10 jump target
i_or_d  output  1  0 = memory address from PC, 1 = address from ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load instruction register
reg_write  output  1  register file write enable
reg_dst  output  1  1 = rd destination (R-type), 0 = rt
mem_to_reg  output  1  writeback data from memory data register
link  output  1  jal: write PC into $31
li  output  1  writeback the immediate (li)
alu_src_a  output  1  0 = PC, 1 = register A
alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
to_alu  output  3  same encoding as the single-cycle unit: 000 R-type/funct, 001 OR, 010 ADD, 100 SUB, 101 JR, 110 AND, 111 SLT
state  output  4  current state encoding, for debug
instr_done  output  1  one-cycle pulse on the final cycle of each retired instruction
trap  output  1  high while in TRAP
trap_cause  output  2  00 none, 01 illegal opcode, 10 memory timeout; held until reset

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, LIWB=10, TRAP=11.
- Any other state value goes to FETCH next cycle.
- Outputs are decoded from the state register and the opcode only. Every output is 0 unless listed for a state.
- On rst_n low (asynchronous): state=FETCH, wait counter=0, trap_cause=00. All strobes are 0 except FETCH's mem_read, which follows the FETCH decode.
- Supported opcodes:
  - R-type 000000, addi 001000, andi 001100, ori 001101, slti 001010
  - lw 100011, sw 101011, li 010000
  - beq 000100, bne 000101, j 000010, jal 000011
- FETCH: mem_read=1, to_alu=010, alu_src_b=01.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE: alu_src_b=11, to_alu=010 (branch target into ALUOut). Next state by op:
  - lw/sw → MEMADR
  - R-type and the four ALU-immediate ops → EXEC
  - beq/bne → BRANCH
  - j/jal → JUMP
  - li → LIWB
  - any other op → TRAP (cause 01) if TRAP_ILLEGAL=1; else FETCH with instr_done=1
- MEMADR: alu_src_a=1, alu_src_b=10, to_alu=010. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. On mem_ready go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, instr_done=1, then FETCH.
- MEMWR: mem_write=1, i_or_d=1. On mem_ready: instr_done=1, then FETCH.
- EXEC: alu_src_a=1; alu_src_b=00 for R-type, 10 otherwise.
  - to_alu: R-type 000, addi 010, andi 110, ori 001, slti 111.
  - Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1 only for R-type, instr_done=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, to_alu=100, pc_write_cond=1, pc_src=01, branch_ne=(op==bne), instr_done=1, then FETCH.
- JUMP: pc_write=1, pc_src=10, to_alu=101. For jal also reg_write=1 and link=1. instr_done=1, then FETCH.
- LIWB: reg_write=1, li=1, to_alu=010, instr_done=1, then FETCH.
- Latency: 3 cycles for branch, jump and li; 4 for ALU ops and sw; 5 for lw. This assumes mem_ready arrives the same cycle it is requested; each memory state adds one cycle per missed mem_ready.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle a memory state (FETCH/MEMRD/MEMWR) is held without mem_ready.
  - Reaching MEM_TIMEOUT without mem_ready → TRAP with cause 10, memory strobes deasserted.
  - mem_ready in the same cycle the count hits MEM_TIMEOUT wins: normal transition, no trap.
- TRAP: absorbing. All strobes 0, trap=1, trap_cause held. Only rst_n exits.
- Reset mid-instruction: the instruction is abandoned, with no write or PC strobe in the reset cycle or the first cycle after it.

Test Plan:
- Reset, then lw with mem_ready always 1 → states 0,1,2,3,4,0; instr_done pulses once at MEMWB; reg_write only in state 4, with mem_to_reg=1.
- addi then R-type, each 4 cycles → EXEC to_alu=010 with alu_src_b=10, then to_alu=000 with alu_src_b=00; reg_dst=1 in ALUWB for the R-type only.
- bne → BRANCH with pc_write_cond=1, branch_ne=1, to_alu=100, pc_src=01; beq gives the same with branch_ne=0.
- jal → JUMP with pc_write=1, pc_src=10, reg_write=1, link=1; for j, link=0 and reg_write=0.
- mem_ready held low in MEMRD with MEM_TIMEOUT=4 → TRAP after 4 waiting cycles, trap_cause=10; mem_ready rising on the 4th cycle instead → MEMWB.
- Opcode 111111: TRAP_ILLEGAL=1 → TRAP with cause 01, held until rst_n; TRAP_ILLEGAL=0 → FETCH after DECODE with instr_done=1. Asserting rst_n low mid-MEMWR clears state to FETCH immediately.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, with a mem_ready timeout and trap state.
module multicycle_control_unit #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned TO_W         = 5,
    parameter bit          TRAP_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       link,
    output logic       li,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] to_alu,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);

    // state  | meaning
    // FETCH  | read instr at PC, PC+4   DECODE | branch target -> ALUOut
    // MEMADR | effective address        MEMRD/MEMWR | data access, MEMWB | load writeback
    // EXEC   | ALU op                   ALUWB | ALU writeback, BRANCH/JUMP/LIWB | finish
    // TRAP   | absorbing fault state, exits only through rst_n
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_LIWB   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LI    = 6'b010000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic [1:0]      cause_q, cause_d;
    logic            armed_q, armed_d;

    logic op_rtype, op_mem, op_alu, op_branch, op_jump, op_li;
    logic mem_state, wait_expired;

    always_comb begin
        op_rtype  = (op == OP_RTYPE);
        op_mem    = (op == OP_LW) || (op == OP_SW);
        op_alu    = op_rtype || (op == OP_ADDI) || (op == OP_ANDI) ||
                    (op == OP_ORI) || (op == OP_SLTI);
        op_branch = (op == OP_BEQ) || (op == OP_BNE);
        op_jump   = (op == OP_J) || (op == OP_JAL);
        op_li     = (op == OP_LI);
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        wait_expired = (wait_q == WAIT_LAST) && !mem_ready;
    end

    // armed_q is low during reset and the first cycle after it; FETCH holds
    // and suppresses its write/PC strobes until then.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        wait_d  = wait_q;
        armed_d = 1'b1;
        case (state_q)
            S_FETCH: begin
                if (armed_q) begin
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end else if (wait_expired) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end
                end
            end
            S_DECODE: begin
                if (op_mem) begin
                    state_d = S_MEMADR;
                end else if (op_alu) begin
                    state_d = S_EXEC;
                end else if (op_branch) begin
                    state_d = S_BRANCH;
                end else if (op_jump) begin
                    state_d = S_JUMP;
                end else if (op_li) begin
                    state_d = S_LIWB;
                end else if (TRAP_ILLEGAL) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_LIWB:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_state && armed_q && !mem_ready) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cause_q <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        link          = 1'b0;
        li            = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        to_alu        = 3'b000;
        instr_done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                to_alu    = 3'b010;
                alu_src_b = 2'b01;
                ir_write  = mem_ready && armed_q;
                pc_write  = mem_ready && armed_q;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                to_alu     = 3'b010;
                instr_done = !(op_mem || op_alu || op_branch || op_jump || op_li) && !TRAP_ILLEGAL;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                to_alu    = 3'b010;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = op_rtype ? 2'b00 : 2'b10;
                case (op)
                    OP_ADDI: to_alu = 3'b010;
                    OP_ANDI: to_alu = 3'b110;
                    OP_ORI:  to_alu = 3'b001;
                    OP_SLTI: to_alu = 3'b111;
                    default: to_alu = 3'b000;
                endcase
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = op_rtype;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                to_alu        = 3'b100;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                branch_ne     = (op == OP_BNE);
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                to_alu     = 3'b101;
                reg_write  = (op == OP_JAL);
                link       = (op == OP_JAL);
                instr_done = 1'b1;
            end
            S_LIWB: begin
                reg_write  = 1'b1;
                li         = 1'b1;
                to_alu     = 3'b010;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state      = state_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (illegal-op trap on/off)
// driven in lockstep, checked per cycle against a table of expected outputs.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, bnes;
        logic [1:0] pcsrc;
        logic       iord, mrd, mwr, irw, rw, rdst, m2r, lnk, lis, srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic       done, trp;
        logic [1:0] cause;
    } outs_t;

    typedef struct packed { outs_t a; outs_t b; } pair_t;
    typedef struct { logic [5:0] op; logic rdy; outs_t e; } vec_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_LI   = 6'b010000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b0;

    logic       a_pc_write, a_pc_write_cond, a_branch_ne, a_i_or_d, a_mem_read, a_mem_write;
    logic       a_ir_write, a_reg_write, a_reg_dst, a_mem_to_reg, a_link, a_li, a_alu_src_a;
    logic       a_instr_done, a_trap;
    logic [1:0] a_pc_src, a_alu_src_b, a_trap_cause;
    logic [2:0] a_to_alu;
    logic [3:0] a_state;
    logic       b_pc_write, b_pc_write_cond, b_branch_ne, b_i_or_d, b_mem_read, b_mem_write;
    logic       b_ir_write, b_reg_write, b_reg_dst, b_mem_to_reg, b_link, b_li, b_alu_src_a;
    logic       b_instr_done, b_trap;
    logic [1:0] b_pc_src, b_alu_src_b, b_trap_cause;
    logic [2:0] b_to_alu;
    logic [3:0] b_state;

    multicycle_control_unit #(.MEM_TIMEOUT(4), .TO_W(5), .TRAP_ILLEGAL(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond), .branch_ne(a_branch_ne),
        .pc_src(a_pc_src), .i_or_d(a_i_or_d), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .ir_write(a_ir_write), .reg_write(a_reg_write), .reg_dst(a_reg_dst),
        .mem_to_reg(a_mem_to_reg), .link(a_link), .li(a_li), .alu_src_a(a_alu_src_a),
        .alu_src_b(a_alu_src_b), .to_alu(a_to_alu), .state(a_state),
        .instr_done(a_instr_done), .trap(a_trap), .trap_cause(a_trap_cause)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(4), .TO_W(5), .TRAP_ILLEGAL(1'b0)) u_dut_nt (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .branch_ne(b_branch_ne),
        .pc_src(b_pc_src), .i_or_d(b_i_or_d), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .ir_write(b_ir_write), .reg_write(b_reg_write), .reg_dst(b_reg_dst),
        .mem_to_reg(b_mem_to_reg), .link(b_link), .li(b_li), .alu_src_a(b_alu_src_a),
        .alu_src_b(b_alu_src_b), .to_alu(b_to_alu), .state(b_state),
        .instr_done(b_instr_done), .trap(b_trap), .trap_cause(b_trap_cause)
    );

    outs_t got_a, got_b;
    assign got_a = {a_state, a_pc_write, a_pc_write_cond, a_branch_ne, a_pc_src, a_i_or_d,
                    a_mem_read, a_mem_write, a_ir_write, a_reg_write, a_reg_dst, a_mem_to_reg,
                    a_link, a_li, a_alu_src_a, a_alu_src_b, a_to_alu, a_instr_done, a_trap,
                    a_trap_cause};
    assign got_b = {b_state, b_pc_write, b_pc_write_cond, b_branch_ne, b_pc_src, b_i_or_d,
                    b_mem_read, b_mem_write, b_ir_write, b_reg_write, b_reg_dst, b_mem_to_reg,
                    b_link, b_li, b_alu_src_a, b_alu_src_b, b_to_alu, b_instr_done, b_trap,
                    b_trap_cause};

    always #5 clk = ~clk;

    function automatic outs_t f_st(input logic [3:0] v);    outs_t o = '0; o.st = v;    return o; endfunction
    function automatic outs_t f_pcsrc(input logic [1:0] v); outs_t o = '0; o.pcsrc = v; return o; endfunction
    function automatic outs_t f_srcb(input logic [1:0] v);  outs_t o = '0; o.srcb = v;  return o; endfunction
    function automatic outs_t f_alu(input logic [2:0] v);   outs_t o = '0; o.alu = v;   return o; endfunction
    function automatic outs_t f_cause(input logic [1:0] v); outs_t o = '0; o.cause = v; return o; endfunction
    function automatic outs_t k_pcw();  outs_t o = '0; o.pcw = 1'b1;  return o; endfunction
    function automatic outs_t k_pcwc(); outs_t o = '0; o.pcwc = 1'b1; return o; endfunction
    function automatic outs_t k_bnes(); outs_t o = '0; o.bnes = 1'b1; return o; endfunction
    function automatic outs_t k_iord(); outs_t o = '0; o.iord = 1'b1; return o; endfunction
    function automatic outs_t k_mrd();  outs_t o = '0; o.mrd = 1'b1;  return o; endfunction
    function automatic outs_t k_mwr();  outs_t o = '0; o.mwr = 1'b1;  return o; endfunction
    function automatic outs_t k_irw();  outs_t o = '0; o.irw = 1'b1;  return o; endfunction
    function automatic outs_t k_rw();   outs_t o = '0; o.rw = 1'b1;   return o; endfunction
    function automatic outs_t k_rdst(); outs_t o = '0; o.rdst = 1'b1; return o; endfunction
    function automatic outs_t k_m2r();  outs_t o = '0; o.m2r = 1'b1;  return o; endfunction
    function automatic outs_t k_lnk();  outs_t o = '0; o.lnk = 1'b1;  return o; endfunction
    function automatic outs_t k_lis();  outs_t o = '0; o.lis = 1'b1;  return o; endfunction
    function automatic outs_t k_srca(); outs_t o = '0; o.srca = 1'b1; return o; endfunction
    function automatic outs_t k_done(); outs_t o = '0; o.done = 1'b1; return o; endfunction
    function automatic outs_t k_trp();  outs_t o = '0; o.trp = 1'b1;  return o; endfunction

    int    n_chk = 0;
    int    n_err = 0;
    vec_t  tbl[$];
    pair_t sb[$];

    outs_t e_fw, e_fr, e_dec, e_madr, e_mrd, e_mwb, e_mwr_wait, e_mwr_go;
    outs_t e_awb, e_awb_r, e_beq, e_bne, e_j, e_jal, e_liwb, e_trap_to, e_trap_il;

    task automatic chk(input string tag, input outs_t got, input outs_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (state got %0d exp %0d)",
                     tag, got, exp, got.st, exp.st);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic r, input outs_t e);
        tbl.push_back('{op: o, rdy: r, e: e});
    endtask

    // Drive one cycle's inputs, queue its expectations, compare at the falling edge.
    task automatic step(input string tag, input logic [5:0] o, input logic r,
                        input outs_t ea, input outs_t eb);
        pair_t p;
        op = o;
        mem_ready = r;
        sb.push_back(pair_t'({ea, eb}));
        @(negedge clk);
        p = sb.pop_front();
        chk({tag, " trap_on"}, got_a, p.a);
        chk({tag, " trap_off"}, got_b, p.b);
        @(posedge clk);
        #1;
    endtask

    task automatic add_exec(input logic [5:0] o, input outs_t ex, input outs_t wb);
        add(o, 1'b1, e_fr);
        add(o, 1'b1, e_dec);
        add(o, 1'b1, ex);
        add(o, 1'b1, wb);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        e_fw       = outs_t'(f_st(4'd0) | k_mrd() | f_alu(3'b010) | f_srcb(2'b01));
        e_fr       = outs_t'(e_fw | k_irw() | k_pcw());
        e_dec      = outs_t'(f_st(4'd1) | f_srcb(2'b11) | f_alu(3'b010));
        e_madr     = outs_t'(f_st(4'd2) | k_srca() | f_srcb(2'b10) | f_alu(3'b010));
        e_mrd      = outs_t'(f_st(4'd3) | k_mrd() | k_iord());
        e_mwb      = outs_t'(f_st(4'd4) | k_rw() | k_m2r() | k_done());
        e_mwr_wait = outs_t'(f_st(4'd5) | k_mwr() | k_iord());
        e_mwr_go   = outs_t'(e_mwr_wait | k_done());
        e_awb      = outs_t'(f_st(4'd7) | k_rw() | k_done());
        e_awb_r    = outs_t'(e_awb | k_rdst());
        e_beq      = outs_t'(f_st(4'd8) | k_srca() | f_alu(3'b100) | k_pcwc() | f_pcsrc(2'b01) | k_done());
        e_bne      = outs_t'(e_beq | k_bnes());
        e_j        = outs_t'(f_st(4'd9) | k_pcw() | f_pcsrc(2'b10) | f_alu(3'b101) | k_done());
        e_jal      = outs_t'(e_j | k_rw() | k_lnk());
        e_liwb     = outs_t'(f_st(4'd10) | k_rw() | k_lis() | f_alu(3'b010) | k_done());
        e_trap_to  = outs_t'(f_st(4'd11) | k_trp() | f_cause(2'b10));
        e_trap_il  = outs_t'(f_st(4'd11) | k_trp() | f_cause(2'b01));

        // lw: 5 cycles, sw: 4 cycles
        add(OP_LW, 1'b1, e_fr); add(OP_LW, 1'b1, e_dec); add(OP_LW, 1'b1, e_madr);
        add(OP_LW, 1'b1, e_mrd); add(OP_LW, 1'b1, e_mwb);
        add(OP_SW, 1'b1, e_fr); add(OP_SW, 1'b1, e_dec); add(OP_SW, 1'b1, e_madr);
        add(OP_SW, 1'b1, e_mwr_go);
        add_exec(OP_ADDI, outs_t'(f_st(4'd6) | k_srca() | f_srcb(2'b10) | f_alu(3'b010)), e_awb);
        add_exec(OP_R,    outs_t'(f_st(4'd6) | k_srca()), e_awb_r);
        add_exec(OP_ANDI, outs_t'(f_st(4'd6) | k_srca() | f_srcb(2'b10) | f_alu(3'b110)), e_awb);
        add_exec(OP_ORI,  outs_t'(f_st(4'd6) | k_srca() | f_srcb(2'b10) | f_alu(3'b001)), e_awb);
        add_exec(OP_SLTI, outs_t'(f_st(4'd6) | k_srca() | f_srcb(2'b10) | f_alu(3'b111)), e_awb);
        add(OP_BNE, 1'b1, e_fr); add(OP_BNE, 1'b1, e_dec); add(OP_BNE, 1'b1, e_bne);
        add(OP_BEQ, 1'b1, e_fr); add(OP_BEQ, 1'b1, e_dec); add(OP_BEQ, 1'b1, e_beq);
        add(OP_JAL, 1'b1, e_fr); add(OP_JAL, 1'b1, e_dec); add(OP_JAL, 1'b1, e_jal);
        add(OP_J,   1'b1, e_fr); add(OP_J,   1'b1, e_dec); add(OP_J,   1'b1, e_j);
        add(OP_LI,  1'b1, e_fr); add(OP_LI,  1'b1, e_dec); add(OP_LI,  1'b1, e_liwb);
        // fetch wait, then lw whose data arrives on the 4th (last allowed) cycle
        add(OP_LW, 1'b0, e_fw); add(OP_LW, 1'b1, e_fr); add(OP_LW, 1'b1, e_dec);
        add(OP_LW, 1'b1, e_madr);
        for (int k = 0; k < 3; k++) add(OP_LW, 1'b0, e_mrd);
        add(OP_LW, 1'b1, e_mrd); add(OP_LW, 1'b1, e_mwb);
        // lw whose data never arrives: 4 waiting cycles then TRAP, absorbing
        add(OP_LW, 1'b1, e_fr); add(OP_LW, 1'b1, e_dec); add(OP_LW, 1'b1, e_madr);
        for (int k = 0; k < 4; k++) add(OP_LW, 1'b0, e_mrd);
        add(OP_LW, 1'b1, e_trap_to); add(OP_R, 1'b1, e_trap_to); add(OP_LW, 1'b0, e_trap_to);

        // reset state, with mem_ready high to expose any unmasked fetch strobe
        rst_n = 1'b0;
        op = OP_R;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("reset trap_on", got_a, e_fw);
        chk("reset trap_off", got_b, e_fw);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("first_after_reset", OP_LW, 1'b1, e_fw, e_fw);

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("row%0d", i), tbl[i].op, tbl[i].rdy, tbl[i].e, tbl[i].e);

        // reset out of TRAP clears cause
        rst_n = 1'b0;
        #1;
        chk("reset_from_trap trap_on", got_a, e_fw);
        chk("reset_from_trap trap_off", got_b, e_fw);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("dead_cycle_1", OP_SW, 1'b1, e_fw, e_fw);

        // reset asserted mid-MEMWR abandons the store at once
        step("sw_fetch", OP_SW, 1'b1, e_fr, e_fr);
        step("sw_decode", OP_SW, 1'b1, e_dec, e_dec);
        step("sw_memadr", OP_SW, 1'b1, e_madr, e_madr);
        step("sw_memwr_wait", OP_SW, 1'b0, e_mwr_wait, e_mwr_wait);
        mem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_memwr trap_on", got_a, e_fw);
        chk("rst_mid_memwr trap_off", got_b, e_fw);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("dead_cycle_2", OP_SW, 1'b1, e_fw, e_fw);

        // illegal opcode: trap with cause 01 vs retire as NOP
        step("ill_fetch", OP_ILL, 1'b1, e_fr, e_fr);
        step("ill_decode", OP_ILL, 1'b1, e_dec, outs_t'(e_dec | k_done()));
        step("ill_after1", OP_ILL, 1'b0, e_trap_il, e_fw);
        step("ill_after2", OP_ILL, 1'b0, e_trap_il, e_fw);
        step("ill_after3", OP_LW, 1'b1, e_trap_il, e_fr);

        rst_n = 1'b0;
        #1;
        chk("reset_from_ill trap_on", got_a, e_fw);
        chk("reset_from_ill trap_off", got_b, e_fw);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("dead_cycle_3", OP_LI, 1'b1, e_fw, e_fw);
        step("li_fetch", OP_LI, 1'b1, e_fr, e_fr);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
